// File: rtl/atan_poly_pkg.sv
// Shared definitions for the atan polynomial pipeline.
//
// Purpose:
//   Provides the pipeline latency constant, the coefficient-select
//   encodings, and the accumulator width derivation. Both the RTL and the
//   testbench import this package.
//
// Contents:
//   LAT         - cycles from acceptance to val_o while the pipe is not stalled
//   coef_sel_e  - coefficient register select (A, B, C, reserved)
//   acc_w()     - accumulator width for the given coefficient and input widths
package atan_poly_pkg;

  localparam int LAT = 4;

  typedef enum logic [1:0] {
    COEF_SEL_A    = 2'd0,
    COEF_SEL_B    = 2'd1,
    COEF_SEL_C    = 2'd2,
    COEF_SEL_RSVD = 2'd3
  } coef_sel_e;

  // The accumulator needs room for three terms. The widest term is
  // A*x^2 (COEF_W + 2*IN_W bits). Two extra bits hold the sum of all
  // three terms, so the sum can never wrap.
  function automatic int acc_w(input int coef_w, input int in_w);
    return coef_w + 2 * in_w + 2;
  endfunction

endpackage

// File: rtl/atan_poly_pipe_if.sv
// Bus interface for atan_poly_pipe.
//
// Purpose:
//   Groups the sample handshake, the coefficient write port and the result
//   handshake into one bundle.
//
// Signals:
//   val_i / rdy_o / data_i            - upstream sample handshake, x unsigned
//   coef_we / coef_sel / coef_data    - coefficient write port
//   val_o / rdy_i / data_o / sat_o    - downstream result handshake
//
// Modports:
//   slave  - the pipeline side (receives samples, produces results)
//   master - the environment side
interface atan_poly_pipe_if #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);

  logic              val_i;
  logic              rdy_o;
  logic [IN_W-1:0]   data_i;
  logic              coef_we;
  logic [1:0]        coef_sel;
  logic [COEF_W-1:0] coef_data;
  logic              val_o;
  logic              rdy_i;
  logic [OUT_W-1:0]  data_o;
  logic              sat_o;

  modport slave (
    input  val_i, data_i, coef_we, coef_sel, coef_data, rdy_i,
    output rdy_o, val_o, data_o, sat_o
  );

  modport master (
    output val_i, data_i, coef_we, coef_sel, coef_data, rdy_i,
    input  rdy_o, val_o, data_o, sat_o
  );

endinterface

// File: rtl/atan_poly_mul.sv
// Registered signed-by-unsigned multiplier with clock enable.
//
// Purpose:
//   Computes o_p = i_a * i_b and registers the result when i_en is high.
//   i_a is signed and i_b is unsigned. The product always fits in AW+BW
//   signed bits.
//
// Ports:
//   clk   in   1       clock, rising edge
//   i_en  in   1       register enable (the pipeline's global advance)
//   i_a   in   AW      signed operand
//   i_b   in   BW      unsigned operand
//   o_p   out  AW+BW   registered signed product
module atan_poly_mul #(
  parameter int AW = 16,
  parameter int BW = 8
) (
  input  logic                 clk,
  input  logic                 i_en,
  input  logic signed [AW-1:0] i_a,
  input  logic        [BW-1:0] i_b,
  output logic signed [AW+BW-1:0] o_p
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_p;

  // Both operands are widened to the product width before multiplying:
  // the signed one by sign extension, the unsigned one with zeros.
  // A PW-wide signed multiply then gives the exact result with no spare
  // bits to discard.
  assign w_a_ext = {{BW{i_a[AW-1]}}, i_a};
  assign w_b_ext = {{AW{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // The product register advances together with the rest of the pipeline
  // and holds its value while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_p <= w_prod;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/atan_poly_pipe.sv
// Pipelined second-order polynomial evaluator, y = A*x^2 + B*x + C.
//
// Purpose:
//   Evaluates a polynomial for atan-style approximation.
//   - x is unsigned Q0.IN_W.
//   - A, B and C are signed Q(COEF_W-12).12 and can be loaded at run time.
//   - Each accepted sample carries the coefficients that were active when
//     it was accepted.
//   - The pipeline has 4 stages and advances on one global enable.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous active-high reset
//   io_bus   slave modport of atan_poly_pipe_if
//            (sample in, coefficient write, result out)
//
// Configuration:
//   ATAN_POLY_SAT_EN  defined   - results outside the OUT_W signed range
//                                 clip to max/min and sat_o is set
//                     undefined - results wrap to the low OUT_W bits and
//                                 sat_o stays 0
module atan_poly_pipe
  import atan_poly_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int COEF_W = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16,
  parameter logic signed [COEF_W-1:0] A_DEF = 16'sh0000,
  parameter logic signed [COEF_W-1:0] B_DEF = 16'sh0C91,
  parameter logic signed [COEF_W-1:0] C_DEF = 16'sh0000
) (
  input  logic clk,
  input  logic rst,
  atan_poly_pipe_if.slave io_bus
);

  localparam int ACC_W = acc_w(COEF_W, IN_W);
  localparam int X2_W  = 2 * IN_W + 1;
  localparam int PA_W  = COEF_W + X2_W;
  localparam int PB_W  = COEF_W + IN_W;

  logic w_en;

  logic signed [COEF_W-1:0] r_coef_a;
  logic signed [COEF_W-1:0] r_coef_b;
  logic signed [COEF_W-1:0] r_coef_c;

  logic                     r_v1;
  logic        [IN_W-1:0]   r_x1;
  logic signed [COEF_W-1:0] r_a1;
  logic signed [COEF_W-1:0] r_b1;
  logic signed [COEF_W-1:0] r_c1;
  logic signed [X2_W-1:0]   w_x2;

  logic                     r_v2;
  logic signed [PA_W-1:0]   w_pa;
  logic signed [PB_W-1:0]   w_pb;
  logic signed [COEF_W-1:0] r_c2;

  logic                     r_v3;
  logic signed [ACC_W-1:0]  w_pa_ext;
  logic signed [ACC_W-1:0]  w_pb_ext;
  logic signed [ACC_W-1:0]  w_c_ext;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [ACC_W-1:0]  w_r;
  logic        [OUT_W-1:0]  w_data_next;
  logic                     w_sat_next;
  logic                     r_val_o;
  logic        [OUT_W-1:0]  r_data_o;
  logic                     r_sat_o;

  // The whole pipe moves as one. It advances whenever the output register
  // is empty or its content is being taken downstream. Bubbles advance like
  // samples, so latency stays fixed at LAT cycles.
  assign w_en          = !r_val_o || io_bus.rdy_i;
  assign io_bus.rdy_o  = w_en;
  assign io_bus.val_o  = r_val_o;
  assign io_bus.data_o = r_data_o;
  assign io_bus.sat_o  = r_sat_o;

  // Active coefficient registers. A write lands even while the pipe is
  // stalled. A sample accepted on the same edge has already snapshotted
  // the old value in stage 1. Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coef_a <= A_DEF;
      r_coef_b <= B_DEF;
      r_coef_c <= C_DEF;
    end else if (io_bus.coef_we) begin
      case (coef_sel_e'(io_bus.coef_sel))
        COEF_SEL_A:    r_coef_a <= io_bus.coef_data;
        COEF_SEL_B:    r_coef_b <= io_bus.coef_data;
        COEF_SEL_C:    r_coef_c <= io_bus.coef_data;
        COEF_SEL_RSVD: ;
        default:       ;
      endcase
    end
  end

  // Stage 1 multiplier: x^2. A zero is prepended to x so the signed
  // multiplier treats it as a non-negative value.
  atan_poly_mul #(.AW(IN_W + 1), .BW(IN_W)) u_mul_x2 (
    .clk  (clk),
    .i_en (w_en),
    .i_a  ({1'b0, io_bus.data_i}),
    .i_b  (io_bus.data_i),
    .o_p  (w_x2)
  );

  // Stage 2 multiplier: A*x^2. x^2 is never negative, so it is passed as
  // the unsigned operand.
  atan_poly_mul #(.AW(COEF_W), .BW(X2_W)) u_mul_pa (
    .clk  (clk),
    .i_en (w_en),
    .i_a  (r_a1),
    .i_b  (w_x2),
    .o_p  (w_pa)
  );

  // Stage 2 multiplier: B*x.
  atan_poly_mul #(.AW(COEF_W), .BW(IN_W)) u_mul_pb (
    .clk  (clk),
    .i_en (w_en),
    .i_a  (r_b1),
    .i_b  (r_x1),
    .o_p  (w_pb)
  );

  // Stage data registers, stages 1 to 3.
  // - Stage 1 captures x and snapshots the coefficients.
  // - Stage 2 carries C alongside the products.
  // - Stage 3 holds the sum.
  // These registers have no reset: their contents only matter under a
  // stage valid bit, and reset clears all the valid bits.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_x1  <= io_bus.data_i;
      r_a1  <= r_coef_a;
      r_b1  <= r_coef_b;
      r_c1  <= r_coef_c;
      r_c2  <= r_c1;
      r_acc <= w_acc_sum;
    end
  end

  // Align all three terms to a common fixed point before summing.
  // - A*x^2 already carries 2*IN_W fraction bits from x.
  // - B*x carries IN_W fraction bits, so it is shifted up by IN_W.
  // - C carries none from x, so it is shifted up by 2*IN_W.
  assign w_pa_ext  = {{(ACC_W - PA_W){w_pa[PA_W-1]}}, w_pa};
  assign w_pb_ext  = {{(ACC_W - PB_W){w_pb[PB_W-1]}}, w_pb};
  assign w_c_ext   = {{(ACC_W - COEF_W){r_c2[COEF_W-1]}}, r_c2};
  assign w_acc_sum = w_pa_ext + (w_pb_ext <<< IN_W) + (w_c_ext <<< (2 * IN_W));

  assign w_r = r_acc >>> SHIFT;

  // Reduce the scaled sum to the output width. The clipped path
  // recognises overflow when the bits from OUT_W-1 upward are not all
  // copies of the sign bit.
  always_comb begin
    w_data_next = w_r[OUT_W-1:0];
    w_sat_next  = 1'b0;
`ifdef ATAN_POLY_SAT_EN
    if (w_r[ACC_W-1:OUT_W-1] != {(ACC_W - OUT_W + 1){w_r[ACC_W-1]}}) begin
      w_sat_next  = 1'b1;
      w_data_next = w_r[ACC_W-1] ? {1'b1, {(OUT_W - 1){1'b0}}}
                                 : {1'b0, {(OUT_W - 1){1'b1}}};
    end
`endif
  end

`ifndef ATAN_POLY_SAT_EN
  // In the wrapping build the bits above OUT_W are simply dropped.
  logic w_unused_hi;
  assign w_unused_hi = ^w_r[ACC_W-1:OUT_W];
`endif

  // Valid chain and output register. Reset drops every in-flight sample
  // and clears the result. While stalled, everything holds so a result
  // that has not been taken stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_val_o  <= 1'b0;
      r_data_o <= '0;
      r_sat_o  <= 1'b0;
    end else if (w_en) begin
      r_v1     <= io_bus.val_i;
      r_v2     <= r_v1;
      r_v3     <= r_v2;
      r_val_o  <= r_v3;
      r_data_o <= w_data_next;
      r_sat_o  <= w_sat_next;
    end
  end

endmodule

// File: tb/tb_atan_poly_pipe.sv
// Self-checking testbench for atan_poly_pipe.
//
// Expected results come from a plain-arithmetic model of
// y = (A*x^2 + B*x*2^8 + C*2^16) >> 16 held in a scoreboard queue. The model
// is followed by saturation or wrap, matching the ATAN_POLY_SAT_EN setting.
// Directed vectors also carry hand-computed constants.
module tb_atan_poly_pipe;
  import atan_poly_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [7:0]  x;
    logic [15:0] expData;
    logic        expSat;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  atan_poly_pipe_if #(.IN_W(8), .COEF_W(16), .OUT_W(16)) bus ();

  atan_poly_pipe dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          outCount = 0;
  bit          lastAccepted = 0;
  bit          prevHeld = 0;
  logic [15:0] prevData = '0;
  logic signed [15:0] mA = 16'sh0000;
  logic signed [15:0] mB = 16'sh0C91;
  logic signed [15:0] mC = 16'sh0000;
  exp_t        expQ[$];
  vec_t        vecs[8];
  logic [7:0]  bpX[8];
  logic [15:0] gotData;
  logic        gotSat;
  int          sent;
  int          outBefore;

  // Safety net so the run always ends, even if the DUT hangs.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got stuck expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Reference model taken straight from the polynomial definition.
  function automatic exp_t model(input logic signed [15:0] a, input logic signed [15:0] b,
                                 input logic signed [15:0] c, input logic [7:0] x);
    longint r;
    longint xi;
    exp_t   e;
    xi = longint'(x);
    r = (longint'(a) * xi * xi + longint'(b) * xi * 256 + longint'(c) * 65536) >>> 16;
    e.sat  = 1'b0;
    e.data = r[15:0];
`ifdef ATAN_POLY_SAT_EN
    if (r > 32767) begin
      e.sat  = 1'b1;
      e.data = 16'h7FFF;
    end else if (r < -32768) begin
      e.sat  = 1'b1;
      e.data = 16'h8000;
    end
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus. Inputs are driven at the falling edge,
  // then the scoreboard looks at what the next rising edge will transfer.
  task automatic applyStimulus(input logic v, input logic [7:0] x, input logic rdy,
                               input logic we, input logic [1:0] sel, input logic [15:0] cd);
    exp_t e;
    @(negedge clk);
    bus.val_i     = v;
    bus.data_i    = x;
    bus.rdy_i     = rdy;
    bus.coef_we   = we;
    bus.coef_sel  = sel;
    bus.coef_data = cd;
    #1;
    checkOutput("rdy_o", 32'(bus.rdy_o), 32'(!bus.val_o || bus.rdy_i));
    if (prevHeld) begin
      checkOutput("hold_val_o", 32'(bus.val_o), 32'd1);
      checkOutput("hold_data_o", 32'(bus.data_o), 32'(prevData));
    end
    if (bus.val_o && bus.rdy_i) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_val_o", 32'(bus.val_o), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_data_o", 32'(bus.data_o), 32'(e.data));
        checkOutput("sb_sat_o", 32'(bus.sat_o), 32'(e.sat));
      end
      outCount++;
    end
    prevHeld = bus.val_o && !bus.rdy_i;
    prevData = bus.data_o;
    lastAccepted = v && bus.rdy_o;
    if (lastAccepted) expQ.push_back(model(mA, mB, mC, x));
    if (we) begin
      case (sel)
        2'd0: mA = cd;
        2'd1: mB = cd;
        2'd2: mC = cd;
        default: ;
      endcase
    end
  endtask

  task automatic loadCoefs(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, COEF_SEL_A, a);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, COEF_SEL_B, b);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, COEF_SEL_C, c);
  endtask

  task automatic waitOutput(input string name, output logic [15:0] d, output logic s);
    bit got;
    got = 0;
    d = '0;
    s = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000);
      if (bus.val_o) begin
        got = 1;
        d = bus.data_o;
        s = bus.sat_o;
      end
    end
    if (!got) checkOutput({name, "_timeout"}, 32'(bus.val_o), 32'd1);
  endtask

  task automatic drainPipe(input string name);
    for (int k = 0; k < 40 && expQ.size() != 0; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000);
    end
    checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.val_i = 1'b0;
    bus.coef_we = 1'b0;
    bus.rdy_i = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    mA = 16'sh0000;
    mB = 16'sh0C91;
    mC = 16'sh0000;
    prevHeld = 0;
    #1;
  endtask

  initial begin
    bus.val_i = 1'b0;
    bus.data_i = '0;
    bus.rdy_i = 1'b1;
    bus.coef_we = 1'b0;
    bus.coef_sel = '0;
    bus.coef_data = '0;

    vecs[0] = '{16'h0000, 16'h0000, 16'h0100, 8'h37, 16'h0100, 1'b0, "const"};
    vecs[1] = '{16'h0000, 16'h1000, 16'h0000, 8'h80, 16'h0800, 1'b0, "linear"};
    vecs[2] = '{16'h1000, 16'h0000, 16'h0000, 8'hFF, 16'h0FE0, 1'b0, "quad"};
    vecs[3] = '{16'h0000, 16'hF000, 16'h0000, 8'h80, 16'hF800, 1'b0, "neg_linear"};
    vecs[4] = '{16'h0000, 16'h0000, 16'h8000, 8'h5A, 16'h8000, 1'b0, "min_exact"};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 16'h0123, 8'h00, 16'h0123, 1'b0, "x_zero"};
`ifdef ATAN_POLY_SAT_EN
    vecs[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 8'hFF, 16'h7FFF, 1'b1, "pos_ovf"};
    vecs[7] = '{16'h8000, 16'h8000, 16'h8000, 8'hFF, 16'h8000, 1'b1, "neg_ovf"};
`else
    vecs[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 8'hFF, 16'h7E7D, 1'b0, "pos_ovf"};
    vecs[7] = '{16'h8000, 16'h8000, 16'h8000, 8'hFF, 16'h817F, 1'b0, "neg_ovf"};
`endif

    // Reset state.
    doReset(2);
    checkOutput("rst_val_o", 32'(bus.val_o), 32'd0);
    checkOutput("rst_data_o", 32'(bus.data_o), 32'd0);
    checkOutput("rst_sat_o", 32'(bus.sat_o), 32'd0);
    checkOutput("rst_rdy_o", 32'(bus.rdy_o), 32'd1);

    // Exact latency: val_o rises exactly LAT cycles after acceptance.
    loadCoefs(16'h0000, 16'h0000, 16'h0100);
    applyStimulus(1'b1, 8'h37, 1'b1, 1'b0, 2'd0, 16'h0000);
    checkOutput("lat_accept", 32'(lastAccepted), 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput($sformatf("lat_val_o_c%0d", k), 32'(bus.val_o), 32'(k == LAT));
    end
    checkOutput("lat_data_o", 32'(bus.data_o), 32'h0100);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      loadCoefs(vecs[i].a, vecs[i].b, vecs[i].c);
      applyStimulus(1'b1, vecs[i].x, 1'b1, 1'b0, 2'd0, 16'h0000);
      waitOutput(vecs[i].name, gotData, gotSat);
      checkOutput({vecs[i].name, "_data"}, 32'(gotData), 32'(vecs[i].expData));
      checkOutput({vecs[i].name, "_sat"}, 32'(gotSat), 32'(vecs[i].expSat));
    end

    // A coefficient written on the acceptance edge applies only to later samples.
    loadCoefs(16'h0000, 16'h1000, 16'h0000);
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b1, COEF_SEL_B, 16'h2000);
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b0, 2'd0, 16'h0000);
    waitOutput("race_first", gotData, gotSat);
    checkOutput("race_first_data", 32'(gotData), 32'h0800);
    waitOutput("race_second", gotData, gotSat);
    checkOutput("race_second_data", 32'(gotData), 32'h1000);

    // Writes to the reserved select change nothing.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, COEF_SEL_RSVD, 16'h7FFF);
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b0, 2'd0, 16'h0000);
    waitOutput("rsvd", gotData, gotSat);
    checkOutput("rsvd_data", 32'(gotData), 32'h1000);

    // Backpressure: 8 samples while rdy_i toggles 1,0,1,0...
    loadCoefs(16'h0200, 16'h0400, 16'h0010);
    for (int i = 0; i < 8; i++) bpX[i] = 8'($urandom);
    sent = 0;
    outBefore = outCount;
    for (int cyc = 0; cyc < 80 && sent < 8; cyc++) begin
      applyStimulus(1'b1, bpX[sent], (cyc % 2) == 0, 1'b0, 2'd0, 16'h0000);
      if (lastAccepted) sent++;
    end
    checkOutput("bp_sent", 32'(sent), 32'd8);
    drainPipe("bp");
    checkOutput("bp_out_count", 32'(outCount - outBefore), 32'd8);

    // Reset with three samples in flight.
    loadCoefs(16'h0000, 16'h2000, 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 2'd0, 16'h0000);
    doReset(1);
    checkOutput("mid_rst_val_o", 32'(bus.val_o), 32'd0);
    checkOutput("mid_rst_data_o", 32'(bus.data_o), 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput($sformatf("post_rst_val_o_c%0d", k), 32'(bus.val_o), 32'd0);
    end
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b0, 2'd0, 16'h0000);
    waitOutput("post_rst", gotData, gotSat);
    checkOutput("post_rst_default_data", 32'(gotData), 32'h0648);
    checkOutput("post_rst_default_sat", 32'(gotSat), 32'd0);

    // Random traffic: random samples, random backpressure, occasional writes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                    ($urandom % 8) == 0, 2'($urandom), 16'($urandom));
    end
    drainPipe("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
